// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/writeback bundle for the iterative RV32M unit.
//   master : issues start/op/operands/rd_addr/flush, observes busy/done and
//            the register-file write port.
//   slave  : the muldiv_unit side.
// Widths come from REGISTER_DATA_W / REGISTER_ADDR_W (register.vh); the
// fallback defines below only apply when register.vh was not seen first.
`ifndef REGISTER_DATA_W
`define REGISTER_DATA_W 32
`endif
`ifndef REGISTER_ADDR_W
`define REGISTER_ADDR_W 5
`endif

interface muldiv_unit_if;
  logic                        start;
  logic [2:0]                  op;
  logic [`REGISTER_DATA_W-1:0] rs1_data;
  logic [`REGISTER_DATA_W-1:0] rs2_data;
  logic [`REGISTER_ADDR_W-1:0] rd_addr;
  logic                        flush;
  logic                        busy;
  logic                        done;
  logic                        wenable;
  logic [`REGISTER_ADDR_W-1:0] waddr;
  logic [`REGISTER_DATA_W-1:0] wdata;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr, flush,
    input  busy, done, wenable, waddr, wdata
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr, flush,
    output busy, done, wenable, waddr, wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit with fixed latency.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave: start/op/rs1_data/rs2_data/rd_addr/flush
//          in; busy/done/wenable/waddr/wdata out (register-file write port)
// op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
// Both multiply and divide work on operand magnitudes for 32 iterations;
// the sign of the result is applied when the result is written back.
// Optional feature: define MULDIV_DIV_EN to build the divider. Without it
// ops 4-7 still take the full latency and write 0.
`ifndef REGISTER_DATA_W
`define REGISTER_DATA_W 32
`endif
`ifndef REGISTER_ADDR_W
`define REGISTER_ADDR_W 5
`endif

module muldiv_unit (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned DATA_W = `REGISTER_DATA_W;
  localparam int unsigned ADDR_W = `REGISTER_ADDR_W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [4:0]          cnt;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   b_q;     // |B|: multiplicand or divisor
  logic [2*DATA_W-1:0] p_q;     // mul: {acc, multiplier}; div: {rem, dividend/quotient}
  logic                neg_q;   // negate the magnitude result on writeback
`ifdef MULDIV_DIV_EN
  logic [DATA_W-1:0]   a_q;     // raw A, returned as remainder on divide by zero
  logic                div0_q;
`endif

  // Operand signedness and magnitudes for the request being accepted.
  logic              a_signed, b_signed, a_neg, b_neg, neg_start;
  logic [DATA_W-1:0] mag_a, mag_b;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (bus.op)
      3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:             a_signed = 1'b1;
      default:          ;
    endcase
    a_neg = a_signed & bus.rs1_data[DATA_W-1];
    b_neg = b_signed & bus.rs2_data[DATA_W-1];
    mag_a = a_neg ? -bus.rs1_data : bus.rs1_data;
    mag_b = b_neg ? -bus.rs2_data : bus.rs2_data;
    // Remainder follows the dividend's sign; everything else is sign(A)^sign(B).
    neg_start = (bus.op[2] & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] p_next;
`ifdef MULDIV_DIV_EN
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_rem;
  logic                div_ge;
`endif

  always_comb begin
    mul_sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, b_q} : '0);
    p_next  = {mul_sum, p_q[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    // Partial remainder stays below the divisor, so 32 bits of the difference suffice.
    div_rem   = div_shift[DATA_W-1:0] - b_q;
    if (op_q[2]) begin
      p_next = {(div_ge ? div_rem : div_shift[DATA_W-1:0]), p_q[DATA_W-2:0], div_ge};
    end
`endif
  end

  // Final signed/selected result from the completed iteration register.
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   result;

  always_comb begin
    prod   = neg_q ? -p_q : p_q;
    result = (op_q == 3'd0) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      if (div0_q)
        result = op_q[1] ? a_q : '1;
      else if (op_q[1])
        result = neg_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
      else
        result = neg_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    end
`else
    if (op_q[2]) result = '0;
`endif
  end

  // The writeback outputs are registered on the edge that leaves DONE, so the
  // done pulse lands 33 edges after acceptance while a start seen on that
  // same edge is still rejected (the state was DONE when it was sampled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      b_q         <= '0;
      p_q         <= '0;
      neg_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q         <= '0;
      div0_q      <= 1'b0;
`endif
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wenable <= 1'b0;
      bus.waddr   <= '0;
      bus.wdata   <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.wenable <= 1'b0;
      bus.waddr   <= '0;
      bus.wdata   <= '0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q     <= bus.op;
            rd_q     <= bus.rd_addr;
            b_q      <= mag_b;
            p_q      <= {{DATA_W{1'b0}}, mag_a};
            neg_q    <= neg_start;
`ifdef MULDIV_DIV_EN
            a_q      <= bus.rs1_data;
            div0_q   <= (bus.rs2_data == '0);
`endif
            cnt      <= '0;
            state    <= CALC;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            p_q <= p_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= DONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (!bus.flush) begin
            bus.done <= 1'b1;
            if (rd_q != '0) begin
              bus.wenable <= 1'b1;
              bus.waddr   <= rd_q;
              bus.wdata   <= result;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed and randomized checks of muldiv_unit against an
// arithmetic reference model of the RV32M results.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wr_count = 0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts cycles in which a register-file write was presented.
  always @(posedge clk) if (bus.wenable === 1'b1) wr_count++;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        pr;
    logic signed [31:0] as, bs;
    logic               ovf;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    as  = a;
    bs  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin pr = {32'b0, a} * {32'b0, b}; r = pr[31:0];  end
      3'd1: begin pr = sa * sb;                 r = pr[63:32]; end
      3'd2: begin pr = sa * ub;                 r = pr[63:32]; end
      3'd3: begin pr = {32'b0, a} * {32'b0, b}; r = pr[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(as / bs);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(as % bs);
      default: r = (b == 0) ? a : a % b;
    endcase
    if (op[2] && !DIV_ON) r = '0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE and checks the full 33-edge timeline.
  // hold=1 keeps start high (with scrambled fields) through the completion edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit hold,
                       input string tag);
    int unsigned w0;
    w0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
    @(posedge clk); #1;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    bus.start    = hold;
    bus.op       = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_addr  = 5'($urandom);
    repeat (32) @(posedge clk);
    #1;
    check({tag, ".early"}, 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".wen"}, 32'(bus.wenable), 32'(rd != 0));
    check({tag, ".waddr"}, 32'(bus.waddr), 32'(rd));
    check({tag, ".wdata"}, bus.wdata, (rd != 0) ? exp : 32'd0);
    @(posedge clk); #1;
    check({tag, ".after"}, {bus.busy, bus.done, bus.wenable, bus.waddr, bus.wdata[24:0]}, 32'd0);
    check({tag, ".after_wdata"}, bus.wdata, 32'd0);
    check({tag, ".writes"}, wr_count - w0, 32'(rd != 0));
  endtask

  initial begin
    int unsigned w0, pulses;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.rd_addr = '0; bus.flush = 1'b0;

    #1;
    check("reset", {bus.busy, bus.done, bus.wenable, bus.waddr, bus.wdata[24:0]}, 32'd0);
    check("reset_wdata", bus.wdata, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    issue(3'd0, 32'd7, 32'hFFFF_FFFA, 5'd3, 32'hFFFF_FFD6, 1'b0, "mul");
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0, "mulhu");
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 1'b0, "mulh");
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, DIV_ON ? 32'hFFFF_FFFD : 32'd0, 1'b0, "div");
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, DIV_ON ? 32'hFFFF_FFFF : 32'd0, 1'b0, "rem");
    issue(3'd5, 32'd5, 32'd0, 5'd8, DIV_ON ? 32'hFFFF_FFFF : 32'd0, 1'b0, "divu0");
    issue(3'd7, 32'd5, 32'd0, 5'd9, DIV_ON ? 32'd5 : 32'd0, 1'b0, "remu0");
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, DIV_ON ? 32'h8000_0000 : 32'd0, 1'b0, "divovf");

    // Extra starts during CALC and on the completion edge are ignored.
    issue(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 5'd11, model(3'd2, 32'h8000_0001, 32'hFFFF_FFFF),
          1'b1, "hold");
    // rd=0: done pulses without a write.
    issue(3'd0, 32'd9, 32'd9, 5'd0, 32'd81, 1'b0, "rd0");

    // start is blocked while flush is high in IDLE.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rd_addr = 5'd1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idle_flush.busy", 32'(bus.busy), 32'd0);

    // Flush in CALC cycle 10: no done, no write.
    w0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.rs1_data = 32'h1234_5678; bus.rs2_data = 32'd3;
    bus.rd_addr = 5'd12;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush.busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("flush.done_pulses", pulses, 32'd0);
    check("flush.writes", wr_count - w0, 32'd0);

    // Reset mid-CALC: outputs clear without a clock, next start accepted at once.
    w0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4;
    bus.rd_addr = 5'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_async", {bus.busy, bus.done, bus.wenable, bus.waddr, bus.wdata[24:0]}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(3'd0, 32'd6, 32'd7, 5'd14, 32'd42, 1'b0, "post_rst");
    check("post_rst.no_abort_write", wr_count - w0, 32'd1);

    // Randomized operations, biased towards the divide corner cases.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(7, 0));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(5, 0))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      rd = 5'($urandom);
      issue(op, a, b, rd, model(op, a, b), (i % 8) == 3, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take data and address widths from REGISTER_DATA_W (32) and REGISTER_ADDR_W (5) in register.vh, with no module parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have the following remaining ports:
- start  in  1  request; sampled only in IDLE.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M).
- rs1_data  in  DATA_W  operand A (register file rdata1).
- rs2_data  in  DATA_W  operand B (register file rdata2).
- rd_addr  in  ADDR_W  destination register.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- wenable  out  1  register file write enable.
- waddr  out  ADDR_W  register file write address.
- wdata  out  DATA_W  register file write data.

Function
REQ-004 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-005 In IDLE with start=1 and flush=0, the block SHALL latch op, both operands and rd_addr, clear the 5-bit counter, and enter CALC.
REQ-006 In CALC, the block SHALL perform one iteration per cycle (shift-add multiply, restoring divide on magnitudes) for exactly 32 cycles, then enter DONE.
REQ-007 In DONE, the block SHALL assert done=1 for one cycle, then return to IDLE.
REQ-008 done SHALL rise exactly 33 cycles after the edge that sampled start; latency SHALL be fixed for all ops and operand values.
REQ-009 While busy=1, the block SHALL ignore start; a start sampled in the same cycle that DONE returns to IDLE SHALL NOT be accepted.
REQ-010 In DONE, the block SHALL assert wenable=1 if the latched rd_addr is nonzero; for rd_addr=0, done SHALL pulse with wenable=0.
REQ-011 waddr and wdata SHALL be valid while wenable=1; they SHALL be 0 at all other times.
REQ-012 MUL SHALL return low 32 bits of the product; MULH, MULHSU and MULHU SHALL return the high 32 bits of the 64-bit product (signed×signed, signed×unsigned, unsigned×unsigned).
REQ-013 DIV and REM SHALL apply sign correction after the magnitude divide: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-014 For divide by zero, the block SHALL return quotient 0xFFFFFFFF and remainder = A, for signed and unsigned ops.
REQ-015 For signed overflow (A=0x80000000, B=0xFFFFFFFF), the block SHALL return DIV=0x80000000 and REM=0.
REQ-016 Special cases SHALL keep the 33-cycle latency.
REQ-017 flush=1 in CALC or DONE SHALL force IDLE on the next edge, with done=0 and wenable=0 from that edge on.
REQ-018 flush=1 in IDLE SHALL block acceptance of start in that cycle.
REQ-019 Changes on rs1_data, rs2_data, op or rd_addr after acceptance SHALL NOT affect the result.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE and set busy, done, wenable, waddr, wdata and the counter to 0, regardless of clk.
REQ-021 Reset asserted mid-CALC SHALL discard the operation with no write, and the first edge after deassertion SHALL accept start.

Configuration
REQ-022 With MULDIV_DIV_EN defined, all eight ops SHALL be implemented as specified.
REQ-023 Without MULDIV_DIV_EN, no divider logic SHALL be present; ops 4-7 SHALL complete with the same 33-cycle latency and write wdata=0 (with wenable per REQ-010).

Verification
REQ-024 start op=MUL A=7 B=0xFFFFFFFA rd=3 -> after 33 cycles done=1, wenable=1, waddr=3, wdata=0xFFFFFFD6.
REQ-025 op=MULHU A=B=0xFFFFFFFF, then op=MULH with the same operands -> wdata=0xFFFFFFFE, then wdata=0x00000000.
REQ-026 DIV A=0xFFFFFFF9 (-7) B=2, then REM with the same operands -> wdata=0xFFFFFFFD, then wdata=0xFFFFFFFF.
REQ-027 DIVU A=5 B=0 gives wdata=0xFFFFFFFF; REMU A=5 B=0 gives wdata=5; DIV A=0x80000000 B=0xFFFFFFFF gives wdata=0x80000000 -> all at 33 cycles.
REQ-028 start asserted repeatedly during CALC, flush at CALC cycle 10, and rd=0 on a separate op -> extra starts ignored; flush causes no done or write; rd=0 gives done=1 with wenable=0.
REQ-029 rst_n pulsed low mid-CALC, then start on the first edge after release -> all outputs 0 asynchronously, no write from the aborted op, and the new op completes at 33 cycles.
